warp_stall_tracker: RTL
=======================

# warp_stall_tracker

Per-warp stall bookkeeping that produces the `warp_stalled` vector consumed by the warp scheduler. On every issue it marks the issued warp stalled, either for a fixed ALU latency or until its memory response returns. This closes the loop between scheduler output and scheduler eligibility. Sits between the issue stage (inputs), the memory return path (completion), and the scheduler (`warp_stalled` output).

## Interface
Parameters:
- `NUM_WARPS`, 32, number of warps tracked.
- `WIDX`, 5, warp index width (log2 `NUM_WARPS`).
- `CNT_W`, 4, ALU latency counter width; max latency 2^`CNT_W`-1.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `issue_valid` in 1: an instruction was issued this cycle.
- `issue_warp` in `WIDX`: warp index of the issued instruction.
- `issue_mem` in 1: 1 = long-latency memory op; 0 = fixed-latency op.
- `issue_lat` in `CNT_W`: stall cycles for a fixed-latency op; ignored when `issue_mem`=1.
- `mem_done_valid` in 1: memory response returned.
- `mem_done_warp` in `WIDX`: warp the response belongs to.
- `warp_stalled` out `NUM_WARPS`: bit w = warp w must not be scheduled.
- `mem_outstanding` out `WIDX`+1: number of warps currently in MEM_WAIT (0..`NUM_WARPS`).
- `err_double_issue` out 1: one-cycle pulse, issue to a warp that was already stalled.
- `err_spurious_done` out 1: one-cycle pulse, completion for a warp not in MEM_WAIT.

## Operation
- Each warp slot has three states: IDLE, ALU_WAIT (down-counter `cnt` nonzero), and MEM_WAIT.
- `warp_stalled[w]` is 1 in ALU_WAIT or MEM_WAIT. It is decoded purely from registered state, with no input-to-output combinational path.
- Issue with `issue_mem`=0 and `issue_lat`=L>0: IDLE→ALU_WAIT with `cnt`=L. `cnt` decrements each cycle; the slot returns to IDLE when `cnt` reaches 0.
- Issue with `issue_mem`=0 and L=0: no state change and no stall.
- Issue with `issue_mem`=1: IDLE→MEM_WAIT, and `mem_outstanding` increments.
- `mem_done_valid` for a warp in MEM_WAIT: MEM_WAIT→IDLE, and `mem_outstanding` decrements.
- Issue legality is checked against the registered state at the start of the cycle. An issue to a stalled warp is dropped (state unchanged) and pulses `err_double_issue` on the next cycle.
- A completion to a warp not in MEM_WAIT is dropped and pulses `err_spurious_done` on the next cycle. This includes a completion arriving in the same cycle as that warp's memory issue.
- Simultaneous completion for warp A and issue for a different warp B: both take effect. If B is a memory issue, `mem_outstanding` is net unchanged.
- Simultaneous completion and issue to the same warp W, with W in MEM_WAIT:
  - the issue is an error (W was stalled at the start of the cycle);
  - the completion still frees W.
- Index arithmetic: `issue_warp` and `mem_done_warp` are used modulo `NUM_WARPS`. No out-of-range slot exists when `NUM_WARPS` = 2^`WIDX`.
- `mem_outstanding` never wraps; by construction it stays in 0..`NUM_WARPS`.

## Timing
- Reset values:
  - all slots IDLE, `cnt`=0;
  - `warp_stalled`=0, `mem_outstanding`=0;
  - both error pulses 0.
- Stall latency: an issue sampled at edge t sets `warp_stalled[w]`=1 from cycle t+1.
- Fixed-latency ops: stall lasts exactly L cycles, so the warp is visible as eligible again at cycle t+L+1.
- Memory ops: a completion sampled at edge t clears the stall from cycle t+1.
- Error pulses are exactly one cycle wide, asserted at t+1.
- Reset asserted mid-operation: all pending stalls and the outstanding count are discarded on that edge, with no error pulses. Inputs sampled in the reset cycle are ignored.

## Configuration
- `WARP_STALL_PERF_EN` defined:
  - adds output `stall_all_cycles` [31:0], which counts cycles in which `warp_stalled` is all-ones;
  - the counter saturates at 0xFFFF_FFFF and is cleared by `reset`.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `warp_sched_pkg` holds:
  - `NUM_WARPS`, `WIDX` constants;
  - `warp_idx_t` typedef;
  - slot state enum `stall_state_t` {IDLE, ALU_WAIT, MEM_WAIT}.
- Sub-module `warp_stall_slot`, one instance per warp via generate. It contains the state, `cnt`, and per-slot error qualification. The top level decodes issue/completion one-hot, ORs the per-slot errors, and maintains `mem_outstanding`.

## Test plan
- Reset, then issue warp 3 with L=3 → `warp_stalled`=0x8 for exactly 3 cycles, then 0; no error pulses.
- Memory issue to warps 0 and 31 → `mem_outstanding`=2, `warp_stalled`=0x8000_0001. Completion for warp 0 → 0x8000_0000 next cycle, `mem_outstanding`=1.
- Issue warp 5 (L=2), then issue warp 5 again next cycle → second issue dropped, `err_double_issue` pulses once, stall still ends on the original schedule.
- Completion for idle warp 7 → `err_spurious_done` pulse, `mem_outstanding` unchanged at 0.
- Same cycle: completion for warp 2 (in MEM_WAIT) and memory issue for warp 4 → `mem_outstanding` unchanged, stall moves from bit 2 to bit 4.
- Memory-issue all 32 warps, then assert `reset` for one cycle → `warp_stalled`=0 and `mem_outstanding`=0 next cycle. With `WARP_STALL_PERF_EN` defined, `stall_all_cycles` counts the all-stalled cycles before the reset, then reads 0.

Source files
------------

// File: rtl/warp_sched_pkg.sv
// Shared warp scheduler types and constants.
// Used by the stall tracker and its per-warp slots.
package warp_sched_pkg;

  localparam int NUM_WARPS = 32;
  localparam int WIDX      = 5;

  typedef logic [WIDX-1:0] warp_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    ALU_WAIT,
    MEM_WAIT
  } stall_state_t;

endpackage

// File: rtl/warp_stall_slot.sv
// One warp's stall state: idle, fixed-latency countdown or memory wait.
// Legality is judged against the state held at the start of the cycle.
module warp_stall_slot #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_hit_i,
  input  logic             issue_mem_i,
  input  logic [CNT_W-1:0] issue_lat_i,
  input  logic             done_hit_i,
  output logic             stalled_o,
  output logic             mem_start_o,
  output logic             mem_end_o,
  output logic             err_dbl_o,
  output logic             err_spur_o
);
  import warp_sched_pkg::*;

  stall_state_t     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_dbl_q;
  logic             err_spur_q;
  logic             in_mem;
  logic             issue_ok;

  assign in_mem      = (state_q == MEM_WAIT);
  assign stalled_o   = (state_q != IDLE);
  assign issue_ok    = issue_hit_i & ~stalled_o;
  assign mem_start_o = issue_ok & issue_mem_i;
  assign mem_end_o   = done_hit_i & in_mem;
  assign err_dbl_o   = err_dbl_q;
  assign err_spur_o  = err_spur_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      err_dbl_q  <= 1'b0;
      err_spur_q <= 1'b0;
    end else begin
      err_dbl_q  <= issue_hit_i & stalled_o;
      err_spur_q <= done_hit_i & ~in_mem;
      unique case (state_q)
        IDLE: begin
          if (issue_ok) begin
            if (issue_mem_i) begin
              state_q <= MEM_WAIT;
            end else if (issue_lat_i != '0) begin
              state_q <= ALU_WAIT;
              cnt_q   <= issue_lat_i;
            end
          end
        end
        ALU_WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= IDLE;
          end
        end
        MEM_WAIT: begin
          if (mem_end_o) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/warp_stall_tracker.sv
// Per-warp stall vector feeding the scheduler's eligibility check.
// Optional WARP_STALL_PERF_EN adds an all-warps-stalled cycle counter.
module warp_stall_tracker #(
  parameter int NUM_WARPS = 32,
  parameter int WIDX      = 5,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [WIDX-1:0]      issue_warp,
  input  logic                 issue_mem,
  input  logic [CNT_W-1:0]     issue_lat,
  input  logic                 mem_done_valid,
  input  logic [WIDX-1:0]      mem_done_warp,
  output logic [NUM_WARPS-1:0] warp_stalled,
  output logic [WIDX:0]        mem_outstanding,
  output logic                 err_double_issue,
  output logic                 err_spurious_done
`ifdef WARP_STALL_PERF_EN
  ,
  output logic [31:0]          stall_all_cycles
`endif
);
  import warp_sched_pkg::*;

  logic [NUM_WARPS-1:0] issue_hit;
  logic [NUM_WARPS-1:0] done_hit;
  logic [NUM_WARPS-1:0] mem_start;
  logic [NUM_WARPS-1:0] mem_end;
  logic [NUM_WARPS-1:0] err_dbl;
  logic [NUM_WARPS-1:0] err_spur;
  logic [WIDX:0]        outst_q;
  logic [WIDX:0]        outst_d;
  logic                 mem_inc;
  logic                 mem_dec;

  // Indices wrap modulo NUM_WARPS so a non power-of-two count stays safe
  always_comb begin
    issue_hit = '0;
    done_hit  = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      issue_hit[w] = issue_valid &&
        ((32'(issue_warp) % 32'(NUM_WARPS)) == 32'(w));
      done_hit[w]  = mem_done_valid &&
        ((32'(mem_done_warp) % 32'(NUM_WARPS)) == 32'(w));
    end
  end

  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_slot
    warp_stall_slot #(.CNT_W(CNT_W)) u_slot (
      .clk         (clk),
      .reset       (reset),
      .issue_hit_i (issue_hit[g]),
      .issue_mem_i (issue_mem),
      .issue_lat_i (issue_lat),
      .done_hit_i  (done_hit[g]),
      .stalled_o   (warp_stalled[g]),
      .mem_start_o (mem_start[g]),
      .mem_end_o   (mem_end[g]),
      .err_dbl_o   (err_dbl[g]),
      .err_spur_o  (err_spur[g])
    );
  end

  assign mem_inc = |mem_start;
  assign mem_dec = |mem_end;

  always_comb begin
    outst_d = outst_q;
    unique case (1'b1)
      mem_inc && !mem_dec: outst_d = outst_q + 1'b1;
      mem_dec && !mem_inc: outst_d = outst_q - 1'b1;
      default:             outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outst_q <= '0;
    end else begin
      outst_q <= outst_d;
    end
  end

  assign mem_outstanding   = outst_q;
  assign err_double_issue  = |err_dbl;
  assign err_spurious_done = |err_spur;

`ifdef WARP_STALL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= '0;
    end else if ((&warp_stalled) && !(&perf_q)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign stall_all_cycles = perf_q;
`else
  // Counter and port are compiled out in the default build
`endif

endmodule
